// File: rtl/fp_power_accel.sv
// fp_power_accel: memory-mapped FP32 buffer that raises a wrapping window of words to the power 1..4 in place
// Ports: clk, rst_n (sync, active-low); host wen/addr/din writes and registered dout reads while idle;
// start launches a run over len words from base with exponent mode+1; bsy is high during a run, done pulses at its end.
// ACCEL_ABORT_EN adds input abort, which ends a run early (a coinciding write is dropped) and pulses done.
module fp_power_accel #(
  parameter int DEPTH = 32,
  parameter int MUL_LAT = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef ACCEL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          wen,
  input  logic          start,
  input  logic [31:0]   addr,
  input  logic [31:0]   din,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  output logic [31:0]   dout,
  output logic          bsy,
  output logic          done
);
  localparam int CW = MUL_LAT > 1 ? $clog2(MUL_LAT) : 1;
  typedef enum logic [1:0] {IDLE, READ, MUL, WRITE} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d, k_q, k_d;
  logic [AW-1:0] base_q, base_d, hidx, idx, wa;
  logic [AW:0] len_q, len_d, i_q, i_d;
  logic [31:0] x_q, x_d, acc_q, acc_d, dout_q, dout_d, wd, prod;
  logic [CW-1:0] c_q, c_d;
  logic done_q, done_d, we, last_c, abort_hit, unused;
  logic [31:0] mem [DEPTH];
  // Round-to-nearest-even FP32 multiply; subnormal operands and results flush to signed zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s, an, bn, ai, bi, az, bz, g, st;
    logic [9:0] e;
    logic [47:0] p;
    logic [22:0] m;
    logic [23:0] r;
    s = a[31] ^ b[31];
    an = &a[30:23] & |a[22:0];
    bn = &b[30:23] & |b[22:0];
    ai = &a[30:23] & ~|a[22:0];
    bi = &b[30:23] & ~|b[22:0];
    az = ~|a[30:23];
    bz = ~|b[30:23];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, p[47]};
    m = p[47] ? p[46:24] : p[45:23];
    g = p[47] ? p[23] : p[22];
    st = p[47] ? |p[22:0] : |p[21:0];
    r = {1'b0, m} + {23'b0, g & (st | m[0])};
    e = e + {9'b0, r[23]};
    return (an | bn | (ai & bz) | (bi & az)) ? 32'h7FC0_0000 :
           (ai | bi) ? {s, 8'hFF, 23'b0} :
           (az | bz) ? {s, 31'b0} :
           ($signed(e) > 10'sd254) ? {s, 8'hFF, 23'b0} :
           ($signed(e) < 10'sd1) ? {s, 31'b0} : {s, e[7:0], r[22:0]};
  endfunction
  assign hidx = addr[AW+1:2];
  assign idx = base_q + i_q[AW-1:0];
  assign last_c = c_q == CW'(MUL_LAT - 1);
  assign prod = fmul(acc_q, x_q);
  assign unused = ^{addr[31:AW+2], addr[1:0]};
`ifdef ACCEL_ABORT_EN
  assign abort_hit = abort && state_q != IDLE;
`else
  assign abort_hit = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    base_d = base_q;
    len_d = len_q;
    i_d = i_q;
    x_d = x_q;
    acc_d = acc_q;
    c_d = c_q;
    k_d = k_q;
    dout_d = dout_q;
    done_d = 1'b0;
    we = 1'b0;
    wa = hidx;
    wd = din;
    case (state_q)
      IDLE: begin
        we = wen;
        dout_d = mem[hidx];
        if (start) begin
          mode_d = mode;
          base_d = base;
          len_d = len;
          i_d = '0;
          done_d = len == '0;
          state_d = len == '0 ? IDLE : READ;
        end
      end
      READ: begin
        x_d = mem[idx];
        acc_d = mem[idx];
        dout_d = mem[idx];
        c_d = '0;
        k_d = '0;
        state_d = mode_q == 2'd0 ? WRITE : MUL;
      end
      MUL: begin
        // acc is held for MUL_LAT cycles per multiply, then takes the product
        c_d = last_c ? '0 : c_q + 1'b1;
        acc_d = last_c ? prod : acc_q;
        k_d = last_c ? k_q + 2'd1 : k_q;
        state_d = (last_c && k_d == mode_q) ? WRITE : MUL;
      end
      default: begin
        we = 1'b1;
        wa = idx;
        wd = acc_q;
        i_d = i_q + 1'b1;
        done_d = i_d == len_q;
        state_d = i_d == len_q ? IDLE : READ;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      we = 1'b0;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (rst_n && we) mem[wa] <= wd;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= '0;
      base_q <= '0;
      len_q <= '0;
      i_q <= '0;
      x_q <= '0;
      acc_q <= '0;
      c_q <= '0;
      k_q <= '0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      base_q <= base_d;
      len_q <= len_d;
      i_q <= i_d;
      x_q <= x_d;
      acc_q <= acc_d;
      c_q <= c_d;
      k_q <= k_d;
      dout_q <= dout_d;
      done_q <= done_d;
    end
  assign dout = dout_q;
  assign bsy = state_q != IDLE;
  assign done = done_q;
endmodule

// File: tb/tb_fp_power_accel.sv
// tb_fp_power_accel: two instances (MUL_LAT 1 and 3) checked every cycle against a real-arithmetic model
`timescale 1ns/1ps
module tb_fp_power_accel;
  localparam int D = 32;
  localparam int AW = 5;
  logic clk, rst_n, wen, start;
  logic [31:0] addr, din;
  logic [1:0] mode;
  logic [AW-1:0] base;
  logic [AW:0] len;
  logic [31:0] dout [2];
  logic bsy [2];
  logic done [2];
`ifdef ACCEL_ABORT_EN
  logic abort;
`endif
  int ntest = 0, nfail = 0;
  bit chk_en = 0;
  logic [31:0] rm [2][D];
  bit kn [2][D];
  bit mb [2], ed [2], ev [2];
  logic [31:0] eo [2];
  int me [2], mbase [2], mlen [2], el [2], cy [2];

  fp_power_accel #(.DEPTH(D), .MUL_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
`ifdef ACCEL_ABORT_EN
    .abort(abort),
`endif
    .wen(wen), .start(start), .addr(addr), .din(din), .mode(mode), .base(base), .len(len),
    .dout(dout[0]), .bsy(bsy[0]), .done(done[0]));
  fp_power_accel #(.DEPTH(D), .MUL_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef ACCEL_ABORT_EN
    .abort(abort),
`endif
    .wen(wen), .start(start), .addr(addr), .din(din), .mode(mode), .base(base), .len(len),
    .dout(dout[1]), .bsy(bsy[1]), .done(done[1]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ntest++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic real b2r(input logic [31:0] b);
    real v;
    int e;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2b(input real v);
    logic s;
    int e;
    longint m;
    real f;
    s = v < 0.0;
    e = 127;
    if (v == 0.0) return {s, 31'b0};
    if (s) v = -v;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    f = v * 8388608.0;
    m = longint'($rtoi(f));
    f = f - real'(m);
    if (f > 0.5 || (f == 0.5 && m[0])) m++;
    if (m == 64'd16777216) begin m = 64'd8388608; e++; end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0) return {s, 31'b0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fm(input logic [31:0] a, input logic [31:0] b);
    logic s;
    bit an, bn, ai, bi, az, bz;
    s = a[31] ^ b[31];
    an = a[30:23] == 8'hFF && a[22:0] != 0;
    bn = b[30:23] == 8'hFF && b[22:0] != 0;
    ai = a[30:23] == 8'hFF && a[22:0] == 0;
    bi = b[30:23] == 8'hFF && b[22:0] == 0;
    az = a[30:23] == 0;
    bz = b[30:23] == 0;
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC0_0000;
    if (ai || bi) return {s, 8'hFF, 23'b0};
    if (az || bz) return {s, 31'b0};
    return r2b(b2r(a) * b2r(b));
  endfunction

  function automatic logic [31:0] fpow(input logic [31:0] x, input int e);
    logic [31:0] acc;
    acc = x;
    for (int j = 1; j < e; j++) acc = fm(acc, x);
    return acc;
  endfunction

  function automatic logic [31:0] rv();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 154));
    return r;
  endfunction

  function automatic logic [31:0] widx(input int i);
    return ($urandom & 32'hFFFF_FF83) | (32'(i) << 2);
  endfunction

  // model: state after each rising edge, from the inputs seen at that edge
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mb[k] = 0; ed[k] = 0; eo[k] = 0; ev[k] = 1;
      end else if (!mb[k]) begin
        eo[k] = rm[k][addr[AW+1:2]];
        ev[k] = kn[k][addr[AW+1:2]];
        ed[k] = 0;
        if (wen) begin rm[k][addr[AW+1:2]] = din; kn[k][addr[AW+1:2]] = 1; end
        if (start) begin
          me[k] = int'(mode) + 1; mbase[k] = int'(base); mlen[k] = int'(len);
          if (len == 0) ed[k] = 1;
          else begin mb[k] = 1; el[k] = 0; cy[k] = 0; end
        end
      end else begin
        bit ab;
        int a;
        ab = 0;
`ifdef ACCEL_ABORT_EN
        ab = abort;
`endif
        ed[k] = 0; ev[k] = 0;
        if (ab) begin
          mb[k] = 0; ed[k] = 1;
        end else if (cy[k] == 1 + (me[k] - 1) * (k == 1 ? 3 : 1)) begin
          a = (mbase[k] + el[k]) % D;
          rm[k][a] = fpow(rm[k][a], me[k]);
          el[k]++; cy[k] = 0;
          if (el[k] == mlen[k]) begin mb[k] = 0; ed[k] = 1; end
        end else cy[k]++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("bsy[%0d]", k), bsy[k], mb[k]);
        chk($sformatf("done[%0d]", k), done[k], ed[k]);
        if (ev[k]) chk($sformatf("dout[%0d]", k), dout[k], eo[k]);
      end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic hw(input int i, input logic [31:0] v);
    wen = 1; addr = widx(i); din = v;
    tick();
    wen = 0;
  endtask

  task automatic rd(input int i, output logic [31:0] v);
    addr = widx(i);
    tick();
    v = dout[0];
  endtask

  task automatic run(input logic [1:0] m, input int b, input int l, input bit noise,
                     output int c0, output int c1, output int p0, output int p1);
    int t;
    t = 0;
    mode = m; base = AW'(b); len = (AW+1)'(l); start = 1;
    tick();
    start = 0; wen = 0;
    c0 = 0; c1 = 0; p0 = 0; p1 = 0;
    while ((bsy[0] || bsy[1]) && t < 2000) begin
      c0 += int'(bsy[0]); c1 += int'(bsy[1]);
      p0 += int'(done[0]); p1 += int'(done[1]);
      if (noise && bsy[0] && bsy[1]) begin
        wen = 1'($urandom); start = 1'($urandom); addr = $urandom; din = $urandom;
        mode = 2'($urandom); base = AW'($urandom); len = (AW+1)'($urandom);
      end else begin
        wen = 0; start = 0;
      end
      tick();
      t++;
    end
    wen = 0; start = 0;
    p0 += int'(done[0]); p1 += int'(done[1]);
    chk("run_bound", {31'b0, bsy[0] | bsy[1]}, 32'd0);
  endtask

  initial begin
    int c0, c1, p0, p1, l, b;
    logic [1:0] m;
    logic [31:0] v;
    rst_n = 0; wen = 0; start = 0; addr = 0; din = 0; mode = 0; base = 0; len = 0;
`ifdef ACCEL_ABORT_EN
    abort = 0;
`endif
    repeat (2) tick();
    chk_en = 1;
    chk("rst_bsy", bsy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_dout", dout[0], 0);
    rst_n = 1;
    chk("pin_cube", fpow(32'h3FC0_0000, 3), 32'h4058_0000);
    chk("pin_round", fm(32'h3F80_0001, 32'h3F80_0001), 32'h3F80_0002);
    hw(0, 32'h4000_0000);
    rd(0, v);
    chk("host_rd", v, 32'h4000_0000);
    for (int i = 1; i < D; i++) hw(i, rv());
    hw(1, 32'h3FC0_0000);
    run(2'd2, 0, 2, 0, c0, c1, p0, p1);
    chk("cube_bsy", c0, 8);
    chk("cube_done", p0, 1);
    rd(0, v); chk("cube_w0", v, 32'h4100_0000);
    rd(1, v); chk("cube_w1", v, 32'h4058_0000);
    hw(31, 32'hC000_0000);
    hw(0, 32'h4040_0000);
    run(2'd1, 31, 2, 1, c0, c1, p0, p1);
    rd(31, v); chk("wrap_w31", v, 32'h4080_0000);
    rd(0, v); chk("wrap_w0", v, 32'h4110_0000);
    rd(1, v); chk("wrap_w1", v, 32'h4058_0000);
    run(2'd3, 5, 1, 0, c0, c1, p0, p1);
    chk("lat3_bsy", c1, 11);
    chk("lat1_bsy", c0, 5);
    run(2'd0, 0, 0, 0, c0, c1, p0, p1);
    chk("len0_bsy", c0 + c1, 0);
    chk("len0_done", p0 + p1, 2);
    hw(8, 32'h4000_0000); hw(9, 32'h4040_0000); hw(10, 32'h3F80_0000);
    hw(11, 32'h40A0_0000); hw(12, 32'hC000_0000);
    mode = 2'd1; base = 5'd8; len = 6'd5; start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_bsy", bsy[0] | bsy[1], 0);
    rd(8, v); chk("rst_w8", v, 32'h4080_0000);
    rd(9, v); chk("rst_w9", v, 32'h4110_0000);
    rd(11, v); chk("rst_w11", v, 32'h40A0_0000);
    rd(12, v); chk("rst_w12", v, 32'hC000_0000);
`ifdef ACCEL_ABORT_EN
    hw(16, 32'h4040_0000); hw(17, 32'h4000_0000); hw(18, 32'h4000_0000); hw(19, 32'h4000_0000);
    mode = 2'd1; base = 5'd16; len = 6'd4; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("abort_done", done[0], 1);
    chk("abort_bsy", bsy[0], 0);
    rd(16, v); chk("abort_w16", v, 32'h4110_0000);
    rd(17, v); chk("abort_w17", v, 32'h4000_0000);
`endif
    for (int r = 0; r < 25; r++) begin
      l = $urandom_range(0, D);
      b = $urandom_range(0, D - 1);
      m = 2'($urandom);
      for (int i = 0; i < D - 1; i++) hw(i, rv());
      wen = 1; addr = widx(D - 1); din = rv();
      run(m, b, l, 1, c0, c1, p0, p1);
      chk("rnd_bsy0", c0, l * (2 + int'(m)));
      chk("rnd_bsy1", c1, l * (2 + int'(m) * 3));
      chk("rnd_done", p0 + p1, 2);
      repeat (3) rd($urandom_range(0, D - 1), v);
    end
    tick();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end
endmodule
